instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, one-cycle-latency
// instruction memory interface, single output register with valid/ready
// handshake and redirect support.
// Optional feature macro: IFU_PERF_CNT_EN adds the stall_cycles counter port.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [RAM_ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] rd_pc_reg, rd_pc_next;
  logic        rd_valid_reg, rd_valid_next;
  logic        out_valid_next;
  logic [31:0] out_instr_next, out_pc_next;
  logic        stall;

  assign stall = out_valid && !out_ready;

  // While stalled, re-read the in-flight word so its data is still on
  // imem_rdata in the cycle the stall clears.
  always_comb begin
    if (stall && rd_valid_reg) begin
      imem_addr = rd_pc_reg[RAM_ADDR_BITS+1:2];
    end else begin
      imem_addr = fetch_pc_reg[RAM_ADDR_BITS+1:2];
    end
  end

  // Next-state logic: redirect beats stall, stall beats normal advance.
  always_comb begin
    fetch_pc_next  = fetch_pc_reg;
    rd_pc_next     = rd_pc_reg;
    rd_valid_next  = rd_valid_reg;
    out_valid_next = out_valid;
    out_instr_next = out_instr;
    out_pc_next    = out_pc;
    if (redirect_valid) begin
      // Low two bits of the target are dropped (word alignment).
      fetch_pc_next  = redirect_pc & 32'hFFFF_FFFC;
      rd_valid_next  = 1'b0;
      out_valid_next = 1'b0;
    end else if (!stall) begin
      rd_pc_next    = fetch_pc_reg;
      rd_valid_next = 1'b1;
      fetch_pc_next = fetch_pc_reg + 32'd4;
      if (rd_valid_reg) begin
        out_instr_next = imem_rdata;
        out_pc_next    = rd_pc_reg;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      rd_pc_reg    <= 32'h0;
      rd_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= 32'h0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_pc_reg    <= rd_pc_next;
      rd_valid_reg <= rd_valid_next;
      out_valid    <= out_valid_next;
      out_instr    <= out_instr_next;
      out_pc       <= out_pc_next;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;

  assign stall_cycles = stall_cycles_reg;

  // Saturating count of cycles in which the output is held back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= 32'h0;
    end else if (stall && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end
`endif

endmodule
